// File: rtl/bus_regfile.sv
// Bank of NUM_REGS registers on one shared tri-state bus, with in-place inc/dec and a carry/borrow flag.
// Optional build macro BUS_REGFILE_SATURATE_EN: inc/dec saturate instead of wrapping.
module bus_regfile #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 4,
    localparam int SEL_W   = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ie,
    input  logic                      oe,
    input  logic                      inc,
    input  logic                      dec,
    input  logic [SEL_W-1:0]          wsel,
    input  logic [SEL_W-1:0]          rsel,
    inout  wire  [WIDTH-1:0]          bus,
    output logic                      zero,
    output logic                      carry,
    output logic [NUM_REGS*WIDTH-1:0] q_flat
);

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [WIDTH-1:0] rd_val;
    logic [WIDTH-1:0] wr_old;
    logic             wr_hit;
    logic [WIDTH-1:0] inc_val;
    logic [WIDTH-1:0] dec_val;
    logic             all_ones;
    logic             old_zero;
    logic             wr_en;
    logic [WIDTH-1:0] wr_val;
    logic             carry_en;
    logic             carry_val;

    // Selects are decoded by comparison so an out-of-range index simply matches nothing.
    always_comb begin
        rd_val = '0;
        wr_old = '0;
        wr_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rsel == SEL_W'(i)) rd_val = regs[i];
            if (wsel == SEL_W'(i)) begin
                wr_old = regs[i];
                wr_hit = 1'b1;
            end
        end
    end

    assign bus  = oe ? rd_val : 'z;
    assign zero = (rd_val == '0);

    assign all_ones = &wr_old;
    assign old_zero = (wr_old == '0);

`ifdef BUS_REGFILE_SATURATE_EN
    assign inc_val = all_ones ? wr_old : wr_old + WIDTH'(1);
    assign dec_val = old_zero ? wr_old : wr_old - WIDTH'(1);
`else
    assign inc_val = wr_old + WIDTH'(1);
    assign dec_val = wr_old - WIDTH'(1);
`endif

    always_comb begin
        wr_en     = 1'b0;
        wr_val    = wr_old;
        carry_en  = 1'b0;
        carry_val = 1'b0;
        if (wr_hit) begin
            if (ie) begin
                wr_en     = 1'b1;
                wr_val    = bus;
                carry_en  = 1'b1;
                carry_val = 1'b0;
            end else if (inc && !dec) begin
                wr_en     = 1'b1;
                wr_val    = inc_val;
                carry_en  = 1'b1;
                carry_val = all_ones;
            end else if (dec && !inc) begin
                wr_en     = 1'b1;
                wr_val    = dec_val;
                carry_en  = 1'b1;
                carry_val = old_zero;
            end
        end
    end

    // The CPU datapath clocks this bank on the falling edge.
    always_ff @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            carry <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en && (wsel == SEL_W'(i))) regs[i] <= wr_val;
            end
            if (carry_en) carry <= carry_val;
        end
    end

    always_comb begin
        q_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) q_flat[i*WIDTH +: WIDTH] = regs[i];
    end

endmodule

// File: tb/tb_bus_regfile.sv
// Directed self-checking bench for bus_regfile: a 4-register bank plus a 3-register bank for out-of-range selects.
module tb_bus_regfile;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ie = 1'b0, oe = 1'b0, inc = 1'b0, dec = 1'b0;
    logic [1:0] wsel = '0, rsel = '0;
    logic       bus_en = 1'b0;
    logic [7:0] bus_drv = '0;
    wire  [7:0] bus;
    wire  [7:0] bus3;
    logic       zero, carry, zero3, carry3;
    logic [31:0] q_flat;
    logic [23:0] q_flat3;

    int total = 0;
    int bad   = 0;

`ifdef BUS_REGFILE_SATURATE_EN
    localparam logic [7:0] EXP_INC2  = 8'hFF;
    localparam logic       EXP_ZERO2 = 1'b0;
    localparam logic [7:0] EXP_DEC0  = 8'h00;
`else
    localparam logic [7:0] EXP_INC2  = 8'h00;
    localparam logic       EXP_ZERO2 = 1'b1;
    localparam logic [7:0] EXP_DEC0  = 8'hFF;
`endif

    assign bus  = bus_en ? bus_drv : 'z;
    assign bus3 = bus_en ? bus_drv : 'z;

    always #5 clk = ~clk;

    bus_regfile #(.WIDTH(8), .NUM_REGS(4)) dut (
        .clk(clk), .rst(rst), .ie(ie), .oe(oe), .inc(inc), .dec(dec),
        .wsel(wsel), .rsel(rsel), .bus(bus), .zero(zero), .carry(carry), .q_flat(q_flat)
    );

    bus_regfile #(.WIDTH(8), .NUM_REGS(3)) dut3 (
        .clk(clk), .rst(rst), .ie(ie), .oe(oe), .inc(inc), .dec(dec),
        .wsel(wsel), .rsel(rsel), .bus(bus3), .zero(zero3), .carry(carry3), .q_flat(q_flat3)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic ie_v, input logic oe_v, input logic inc_v, input logic dec_v,
                                 input logic [1:0] ws, input logic [1:0] rs,
                                 input logic be, input logic [7:0] bv);
        ie = ie_v; oe = oe_v; inc = inc_v; dec = dec_v;
        wsel = ws; rsel = rs; bus_en = be; bus_drv = bv;
    endtask

    task automatic clockEdge();
        @(negedge clk);
        #1;
    endtask

    task automatic loadReg(input logic [1:0] ws, input logic [7:0] v);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, ws, 2'd0, 1'b1, v);
        clockEdge();
    endtask

    task automatic readBack(input logic [1:0] rs);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, rs, 1'b0, 8'h00);
        #1;
    endtask

    initial begin
        $display("[TB] start");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 8'h00);
        rst = 1'b1;
        clockEdge();
        clockEdge();
        rst = 1'b0;

        for (int r = 0; r < 4; r++) begin
            readBack(2'(r));
            checkOutput($sformatf("rst_bus%0d", r), {24'h0, bus}, 32'h0);
            checkOutput($sformatf("rst_zero%0d", r), {31'h0, zero}, 32'h1);
        end
        checkOutput("rst_carry", {31'h0, carry}, 32'h0);
        checkOutput("rst_qflat", q_flat, 32'h0);

        // Plain load then read back
        loadReg(2'd2, 8'hA5);
        readBack(2'd2);
        checkOutput("ld_bus", {24'h0, bus}, 32'hA5);
        checkOutput("ld_zero", {31'h0, zero}, 32'h0);
        checkOutput("ld_qflat", q_flat, 32'h00A50000);

        // Increment across the all-ones boundary
        loadReg(2'd1, 8'hFE);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0, 8'h00);
        clockEdge();
        readBack(2'd1);
        checkOutput("inc1_val", {24'h0, bus}, 32'hFF);
        checkOutput("inc1_carry", {31'h0, carry}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0, 8'h00);
        clockEdge();
        readBack(2'd1);
        checkOutput("inc2_val", {24'h0, bus}, {24'h0, EXP_INC2});
        checkOutput("inc2_carry", {31'h0, carry}, 32'h1);
        checkOutput("inc2_zero", {31'h0, zero}, {31'h0, EXP_ZERO2});

        // Decrement from zero, then a load clears the borrow
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 1'b0, 8'h00);
        clockEdge();
        readBack(2'd3);
        checkOutput("dec0_val", {24'h0, bus}, {24'h0, EXP_DEC0});
        checkOutput("dec0_carry", {31'h0, carry}, 32'h1);
        loadReg(2'd3, 8'h10);
        readBack(2'd3);
        checkOutput("ld10_val", {24'h0, bus}, 32'h10);
        checkOutput("ld10_carry", {31'h0, carry}, 32'h0);

        // Load wins over increment
        loadReg(2'd0, 8'h05);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 8'h40);
        clockEdge();
        readBack(2'd0);
        checkOutput("ie_inc_val", {24'h0, bus}, 32'h40);

        // inc+dec together: no change, carry holds its set value
        loadReg(2'd3, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 1'b0, 8'h00);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 8'h00);
        clockEdge();
        readBack(2'd0);
        checkOutput("incdec_val", {24'h0, bus}, 32'h40);
        checkOutput("incdec_carry", {31'h0, carry}, 32'h1);

        // Reset beats a simultaneous load
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 8'h77);
        clockEdge();
        rst = 1'b0;
        checkOutput("rst_ie_qflat", q_flat, 32'h0);
        checkOutput("rst_ie_carry", {31'h0, carry}, 32'h0);

        // Self-reload with ie and oe on the same register clears carry
        loadReg(2'd1, 8'h33);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 8'h00);
        clockEdge();
        checkOutput("pre_self_carry", {31'h0, carry}, 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 1'b0, 8'h00);
        clockEdge();
        checkOutput("self_val", {24'h0, q_flat[15:8]}, 32'h33);
        checkOutput("self_carry", {31'h0, carry}, 32'h0);

        // Out-of-range selects on the 3-register bank
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 8'h00);
        clockEdge();
        rst = 1'b0;
        loadReg(2'd0, 8'h11);
        loadReg(2'd1, 8'h22);
        loadReg(2'd2, 8'h33);
        checkOutput("oor_pre_qflat", {8'h0, q_flat3}, 32'h00332211);
        loadReg(2'd3, 8'h99);
        checkOutput("oor_ld_qflat", {8'h0, q_flat3}, 32'h00332211);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0, 1'b0, 8'h00);
        clockEdge();
        checkOutput("oor_inc_qflat", {8'h0, q_flat3}, 32'h00332211);
        readBack(2'd3);
        checkOutput("oor_bus", {24'h0, bus3}, 32'h0);
        checkOutput("oor_zero", {31'h0, zero3}, 32'h1);
        checkOutput("oor_carry", {31'h0, carry3}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
